// File: rtl/fifo_stream_reader_if.sv
// Signal bundle between the FIFO read port, the stream reader and the
// downstream consumer. The reader (master) drives the FIFO read enable and
// the stream outputs. The environment (slave) drives the FIFO flags, the
// FIFO data and the consumer ready.
interface fifo_stream_reader_if #(
    parameter int width = 9
);
    logic             fifo_empty;
    logic [width-1:0] fifo_dout;
    logic             fifo_rderr;
    logic             fifo_rd_en;
    logic             m_valid;
    logic [width-1:0] m_data;
    logic             m_ready;

    modport master (
        input  fifo_empty, fifo_dout, fifo_rderr, m_ready,
        output fifo_rd_en, m_valid, m_data
    );

    modport slave (
        output fifo_empty, fifo_dout, fifo_rderr, m_ready,
        input  fifo_rd_en, m_valid, m_data
    );
endinterface

// File: rtl/fifo_stream_reader.sv
// Read-side adapter for a non-FWFT block-RAM FIFO.
// It issues FIFO reads under credit control, so that the buffered words plus
// the words still in flight never exceed DEPTH. It lands the returned words
// in a small circular buffer and presents them as a valid/ready stream.
module fifo_stream_reader #(
    parameter int width        = 9,
    parameter int READ_LATENCY = 1,
    parameter int DEPTH        = 4,
    localparam int OCC_W       = $clog2(DEPTH + 1)
) (
    input  logic                 rd_clk,
    input  logic                 rst,
    fifo_stream_reader_if.master bus,
    output logic [OCC_W-1:0]     occupancy,
    output logic                 err
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    // credit can reach DEPTH + READ_LATENCY, so one extra bit is needed
    localparam int CNT_W = OCC_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [OCC_W-1:0] FULL_C  = OCC_W'(DEPTH);
    localparam logic [PTR_W-1:0] LAST_C  = PTR_W'(DEPTH - 1);

    // Parameter sanity: reject illegal combinations at elaboration
    if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_latency
        $error("fifo_stream_reader: READ_LATENCY must be 1 or 2");
    end
    if (DEPTH < READ_LATENCY + 1) begin : g_bad_depth
        $error("fifo_stream_reader: DEPTH must be >= READ_LATENCY+1");
    end

    logic [READ_LATENCY-1:0] stage_reg;
    logic [width-1:0]        buf_mem [DEPTH];
    logic [PTR_W-1:0]        wr_ptr_reg;
    logic [PTR_W-1:0]        rd_ptr_reg;
    logic [OCC_W-1:0]        occ_reg;
    logic [OCC_W-1:0]        occ_next;
    logic                    valid_reg;
    logic                    err_reg;

    logic                    rd_en;
    logic                    pop;
    logic                    capture;
    logic                    full;
    logic                    wr_ok;
    logic [CNT_W-1:0]        inflight;
    logic [CNT_W-1:0]        credit;

    // Credit accounting and the read-issue decision. A pop in this cycle
    // frees one slot, so a read may still go out when credit is exactly DEPTH.
    always_comb begin
        inflight = '0;
        for (int i = 0; i < READ_LATENCY; i++) begin
            inflight = inflight + CNT_W'(stage_reg[i]);
        end
        credit  = CNT_W'(occ_reg) + inflight;
        pop     = valid_reg & bus.m_ready;
        rd_en   = !rst && !bus.fifo_empty &&
                  ((credit < DEPTH_C) || ((credit == DEPTH_C) && pop));
        capture = stage_reg[READ_LATENCY-1];
        full    = (occ_reg == FULL_C);
        // Overflow cannot happen while the credit rule holds. The write is
        // still guarded so that a violation cannot corrupt the live head.
        wr_ok   = capture && (!full || pop);
        occ_next = occ_reg;
        case ({wr_ok, pop})
            2'b10:   occ_next = occ_reg + OCC_W'(1);
            2'b01:   occ_next = occ_reg - OCC_W'(1);
            default: occ_next = occ_reg;
        endcase
    end

    assign bus.fifo_rd_en = rd_en;
    assign bus.m_valid    = valid_reg;
    assign bus.m_data     = buf_mem[rd_ptr_reg];
    assign occupancy      = occ_reg;
    assign err            = err_reg;

    // In-flight read pipeline: one valid bit per cycle of FIFO read latency
    if (READ_LATENCY == 1) begin : g_lat1
        always_ff @(posedge rd_clk) begin
            if (rst) stage_reg <= '0;
            else     stage_reg <= rd_en;
        end
    end else begin : g_latn
        always_ff @(posedge rd_clk) begin
            if (rst) stage_reg <= '0;
            else     stage_reg <= {stage_reg[READ_LATENCY-2:0], rd_en};
        end
    end

    // Buffer storage: write the returned FIFO word when its read lands
    always_ff @(posedge rd_clk) begin
        if (!rst && wr_ok) begin
            buf_mem[wr_ptr_reg] <= bus.fifo_dout;
        end
    end

    // Pointers, occupancy, registered valid and the sticky error flag
    always_ff @(posedge rd_clk) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            occ_reg    <= '0;
            valid_reg  <= 1'b0;
            err_reg    <= 1'b0;
        end else begin
            if (wr_ok) begin
                wr_ptr_reg <= (wr_ptr_reg == LAST_C) ? '0 : wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= (rd_ptr_reg == LAST_C) ? '0 : rd_ptr_reg + 1'b1;
            end
            occ_reg   <= occ_next;
            valid_reg <= (occ_next != '0);
            err_reg   <= err_reg | bus.fifo_rderr | (capture & full);
        end
    end
endmodule
